dmem_responder: RTL
===================

# dmem_responder

Data-memory responder: the memory-side end of the core's load/store interface. It accepts one word-aligned read or write request at a time over a valid/ready handshake, holds it for a programmable number of wait states, and returns a single-cycle response. It also drives `busy` so the core's hazard unit can stall the M stage. Its purpose is to replace the zero-latency data memory model when exercising pipeline stalls.

## Interface
- `DEPTH`, 256: number of 32-bit words. Power of two, 4..65536.
- `WAIT`, 2: wait states between request acceptance and response. Range 0..15.

- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset (0 = reset).
- `req_valid`  in  1  request present.
- `req_ready`  out  1  responder can accept; the handshake occurs when `req_valid` and `req_ready` are both 1 at an edge.
- `req_we`  in  1  1 = write, 0 = read.
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  write data.
- `req_be`  in  4  byte enables for writes; bit i covers byte lane i (`[8i+7:8i]`).
- `rsp_valid`  out  1  response strobe, exactly one cycle per accepted request.
- `rsp_rdata`  out  32  read data, qualified by `rsp_valid`.
- `rsp_err`  out  1  request faulted, qualified by `rsp_valid`.
- `busy`  out  1  a request is in flight (state ≠ IDLE).

## Operation
- **States.** Three states, IDLE, WAIT, RESP, plus a 4-bit countdown `cnt`.
- **IDLE.**
  - `req_ready` = 1.
  - On handshake, capture we/addr/wdata/be and load `cnt` = WAIT−1.
  - Next state is WAIT if WAIT > 0, otherwise RESP.
- **WAIT.**
  - `req_ready` = 0, `cnt` decrements each cycle.
  - When `cnt` = 0, the next state is RESP.
- **RESP.**
  - `rsp_valid` = 1 for this single cycle; there is no response backpressure.
  - Next state is always IDLE.
- **Commit edge.** Execution happens on the edge that enters RESP.
  - Fault check: `addr[1:0]` ≠ 0, or word index `addr[31:2]` ≥ DEPTH.
  - Fault: no array write, `rsp_rdata` = 0, `rsp_err` = 1.
  - Read, no fault: `rsp_rdata` = mem[index], `rsp_err` = 0.
  - Write, no fault: each byte lane with be[i] = 1 is updated. `rsp_rdata` = 0, `rsp_err` = 0. be = 4'b0000 is a legal no-op write.
  - Reads ignore `req_be` and always return the full word.
- **Output registers.** `rsp_rdata` and `rsp_err` hold their values until the next commit edge; their value outside `rsp_valid` carries no meaning.
- **Requests outside IDLE.** Requests presented while not in IDLE are not accepted. The requester must hold them until `req_ready` is 1.
- **Memory contents.** The array is not reset, and its contents are undefined until written.

## Timing
- **Reset values (while `reset` = 0, asynchronous):**
  - state IDLE, `cnt` = 0, `rsp_rdata` = 0, `rsp_err` = 0.
  - `rsp_valid` = 0, `busy` = 0.
  - `req_ready` = 0 while reset is asserted; 1 from the first cycle after release.
- **Latency.** For a handshake at edge k, `rsp_valid` is high during cycle k+1+WAIT.
- **Throughput.** `req_ready` is 1 again in cycle k+2+WAIT, giving one request per WAIT+2 cycles.
- **busy.** High from cycle k+1 through the RESP cycle inclusive. It is derived from registered state only, with no combinational path from `req_valid`.
- **Reset mid-operation.** If reset is asserted before the commit edge, the request is dropped: no write occurs and no `rsp_valid` is produced. If reset is asserted during RESP, `rsp_valid` drops immediately; the write has already committed.
- **Read-after-write.** A write followed by a read to the same word returns the new data. Requests are serialized, so no bypass is needed.
- **Counter range.** `cnt` never wraps. It is loaded only from IDLE and only decremented while nonzero.
- **Address wrap.** Address arithmetic does not wrap. Any index ≥ DEPTH faults, including addresses such as 0xFFFFFFFC.

## Test plan
- **Basic write/read, WAIT=2.**
  - Write 0xDEADBEEF to 0x10 with be=4'hF: `rsp_valid` at cycle k+3, `rsp_err`=0.
  - Read 0x10: `rsp_rdata`=0xDEADBEEF.
  - `req_ready` low for exactly 3 cycles after each accept.
- **Byte enables.**
  - Write 0x11223344 to 0x20, then write 0xAABBCCDD with be=4'b0101.
  - Read 0x20 returns 0x11BB33DD.
- **Faults.**
  - Read 0x13: `rsp_err`=1, `rsp_rdata`=0.
  - Write to 4·DEPTH: `rsp_err`=1, and a subsequent read of word 0 is unchanged.
- **WAIT=0.**
  - Back-to-back requests with `req_valid` held high: accepts every 2nd edge, `rsp_valid` one cycle after each accept, `busy` toggles 1/0.
- **Reset mid-operation.**
  - With WAIT=4, accept a write of 0x55 to 0x8, then pull reset low during WAIT.
  - Result: no `rsp_valid`, outputs at reset values, and a subsequent read of 0x8 returns its previous value.
- **Hold while busy.**
  - Assert `req_valid` with a changing `req_addr` during WAIT: no accept occurs.
  - The address present on the first IDLE edge is the one served.

Source files
------------

// File: rtl/dmem_responder.sv
// Data-memory responder: serves one word-aligned load/store at a time over a
// valid/ready handshake, inserts WAIT wait states, then emits a one-cycle
// response. Used to stand in for a zero-latency data memory when the pipeline
// stall logic needs exercising.
module dmem_responder #(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned WAIT  = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy
);

  localparam int unsigned AW       = $clog2(DEPTH);
  localparam logic [3:0]  CNT_INIT = (WAIT > 0) ? 4'(WAIT - 1) : 4'd0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [31:0] mem [DEPTH];

  logic          accept;
  logic          commit;
  logic          fault;
  logic [AW-1:0] idx;
  logic [3:0]    mem_we;

  // State, countdown, captured request and response registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic: accept in IDLE, count down wait states, one RESP cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    accept  = req_valid && req_ready;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          we_d    = req_we;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          be_d    = req_be;
          cnt_d   = CNT_INIT;
          state_d = (WAIT > 0) ? ST_WAIT : ST_RESP;
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Commit on the edge entering RESP. The _d request fields are used so that
  // with WAIT=0 the live request is executed on its own handshake edge.
  always_comb begin
    commit  = (state_d == ST_RESP) && (state_q != ST_RESP);
    fault   = (addr_d[1:0] != 2'b00) || ({2'b00, addr_d[31:2]} >= 32'(DEPTH));
    idx     = addr_d[AW+1:2];
    rdata_d = rdata_q;
    err_d   = err_q;
    mem_we  = '0;
    if (commit) begin
      err_d   = fault;
      rdata_d = (fault || we_d) ? '0 : mem[idx];
      mem_we  = (!fault && we_d) ? be_d : 4'b0000;
    end
  end

  // Byte-lane writes into the (unreset) storage array.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < 4; i++) begin
      if (mem_we[i]) begin
        mem[idx][8*i +: 8] <= wdata_d[8*i +: 8];
      end
    end
  end

  // Outputs decoded from registered state only.
  always_comb begin
    req_ready = reset && (state_q == ST_IDLE);
    rsp_valid = (state_q == ST_RESP);
    busy      = (state_q != ST_IDLE);
    rsp_rdata = rdata_q;
    rsp_err   = err_q;
  end

endmodule
